// File: rtl/parity_pkg.sv
// Shared definitions for the streaming parity block: FSM state encoding and
// parity mode constants.
package parity_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      HOLD  = 2'd2
   } state_t;

   localparam logic MODE_EVEN = 1'b0;
   localparam logic MODE_ODD  = 1'b1;

endpackage

// File: rtl/parity_word.sv
// Combinational parity of a single data word: 1 when the word holds an odd
// number of ones.
module parity_word #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] data,
   output logic             parity
);

   assign parity = ^data;

endmodule

// File: rtl/parity_stream.sv
// Streaming parity generator/checker: folds the parity of every beat of a
// packet into one bit and presents a single registered result per packet.
module parity_stream
   import parity_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter int MAX_BEATS = 16,
   parameter int CNT_W     = $clog2(MAX_BEATS + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             odd_mode,
   input  logic             check_en,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_last,
   input  logic             in_par,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_parity,
   output logic             out_error,
   output logic [CNT_W-1:0] out_beats,
   output logic             out_ovf
);

   state_t           state;
   logic             acc;
   logic [CNT_W-1:0] cnt;
   logic             ovf;
   logic             chk_q;

   logic             word_par;
   logic             accept;
   logic             first;
   logic             at_max;
   logic             acc_next;
   logic [CNT_W-1:0] cnt_next;
   logic             ovf_next;
   logic             chk_next;

   parity_word #(
      .WIDTH (WIDTH)
   ) u_word (
      .data   (in_data),
      .parity (word_par)
   );

   // No beat is taken while a result waits, nor in the reset cycle itself.
   assign in_ready = (state != HOLD) && !rst;
   assign accept   = in_valid && in_ready;

   // Next accumulator values. The first beat of a packet seeds the fold with
   // the mode bit and samples the check enable; later beats only fold in data.
   always_comb begin
      first    = (state == IDLE);
      at_max   = (cnt == CNT_W'(MAX_BEATS));
      acc_next = first ? (odd_mode ^ word_par) : (acc ^ word_par);
      cnt_next = first ? CNT_W'(1) : (at_max ? cnt : cnt + CNT_W'(1));
      ovf_next = first ? 1'b0 : (ovf | at_max);
      chk_next = first ? check_en : chk_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         acc        <= 1'b0;
         cnt        <= '0;
         ovf        <= 1'b0;
         chk_q      <= 1'b0;
         out_valid  <= 1'b0;
         out_parity <= 1'b0;
         out_error  <= 1'b0;
         out_beats  <= '0;
         out_ovf    <= 1'b0;
      end else begin
         case (state)
            IDLE, ACCUM: begin
               if (accept) begin
                  acc   <= acc_next;
                  cnt   <= cnt_next;
                  ovf   <= ovf_next;
                  chk_q <= chk_next;
                  if (in_last) begin
                     state      <= HOLD;
                     out_valid  <= 1'b1;
                     out_parity <= acc_next;
                     out_error  <= chk_next & (acc_next != in_par);
                     out_beats  <= cnt_next;
                     out_ovf    <= ovf_next;
                  end else begin
                     state <= ACCUM;
                  end
               end
            end
            HOLD: begin
               // Result fields keep their values after the handshake.
               if (out_ready) begin
                  state     <= IDLE;
                  out_valid <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_parity_stream.sv
// Directed bench for parity_stream: single-beat vector table plus hand-written
// multi-beat, back-pressure, saturation and reset sequences.
module tb_parity_stream;
   import parity_pkg::*;

   localparam int WIDTH     = 8;
   localparam int MAX_BEATS = 16;
   localparam int CNT_W     = $clog2(MAX_BEATS + 1);

   logic             clk;
   logic             rst;
   logic             odd_mode;
   logic             check_en;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             in_last;
   logic             in_par;
   logic             out_valid;
   logic             out_ready;
   logic             out_parity;
   logic             out_error;
   logic [CNT_W-1:0] out_beats;
   logic             out_ovf;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic             odd;
      logic             chk;
      logic [WIDTH-1:0] data;
      logic             par;
      logic             exp_par;
      logic             exp_err;
   } vec_t;

   vec_t vecs [8];

   parity_stream #(
      .WIDTH     (WIDTH),
      .MAX_BEATS (MAX_BEATS),
      .CNT_W     (CNT_W)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .odd_mode   (odd_mode),
      .check_en   (check_en),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .in_last    (in_last),
      .in_par     (in_par),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_parity (out_parity),
      .out_error  (out_error),
      .out_beats  (out_beats),
      .out_ovf    (out_ovf)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Drive one cycle of inputs, then advance to 1ns past the next rising edge.
   task automatic applyStimulus(input logic v, input logic [WIDTH-1:0] d, input logic l,
                                input logic o, input logic c, input logic p, input logic r);
      in_valid  = v;
      in_data   = d;
      in_last   = l;
      odd_mode  = o;
      check_en  = c;
      in_par    = p;
      out_ready = r;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic checkResult(input string name, input logic par, input logic err,
                              input int beats, input logic ovf);
      checkOutput({name, "_valid"}, 32'(out_valid), 32'd1);
      checkOutput({name, "_parity"}, 32'(out_parity), 32'(par));
      checkOutput({name, "_error"}, 32'(out_error), 32'(err));
      checkOutput({name, "_beats"}, 32'(out_beats), 32'(beats));
      checkOutput({name, "_ovf"}, 32'(out_ovf), 32'(ovf));
   endtask

   task automatic consume(input string name);
      applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      checkOutput({name, "_valid_drop"}, 32'(out_valid), 32'd0);
      checkOutput({name, "_ready_back"}, 32'(in_ready), 32'd1);
   endtask

   logic             held_par;
   logic [CNT_W-1:0] held_beats;

   initial begin
      vecs[0] = '{MODE_EVEN, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0};
      vecs[1] = '{MODE_ODD,  1'b0, 8'hA5, 1'b0, 1'b1, 1'b0};
      vecs[2] = '{MODE_EVEN, 1'b1, 8'h07, 1'b0, 1'b1, 1'b1};
      vecs[3] = '{MODE_EVEN, 1'b1, 8'h07, 1'b1, 1'b1, 1'b0};
      vecs[4] = '{MODE_ODD,  1'b1, 8'h00, 1'b0, 1'b1, 1'b1};
      vecs[5] = '{MODE_ODD,  1'b1, 8'hFE, 1'b0, 1'b0, 1'b0};
      vecs[6] = '{MODE_EVEN, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0};
      vecs[7] = '{MODE_EVEN, 1'b0, 8'h07, 1'b0, 1'b1, 1'b0};

      rst = 1'b1;
      applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("reset_in_ready", 32'(in_ready), 32'd0);
      checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
      checkOutput("reset_out_parity", 32'(out_parity), 32'd0);
      checkOutput("reset_out_error", 32'(out_error), 32'd0);
      checkOutput("reset_out_beats", 32'(out_beats), 32'd0);
      checkOutput("reset_out_ovf", 32'(out_ovf), 32'd0);
      rst = 1'b0;
      #1;
      checkOutput("post_reset_in_ready", 32'(in_ready), 32'd1);

      // Single-beat packets from the table; result must appear one clock after the beat.
      for (int i = 0; i < 8; i++) begin
         applyStimulus(1'b1, vecs[i].data, 1'b1, vecs[i].odd, vecs[i].chk, vecs[i].par, 1'b0);
         checkResult($sformatf("vec%0d", i), vecs[i].exp_par, vecs[i].exp_err, 1, 1'b0);
         checkOutput($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'd0);
         consume($sformatf("vec%0d", i));
      end

      // Two beats, odd mode; mode/check changes on beat 2 must be ignored.
      applyStimulus(1'b1, 8'h01, 1'b0, MODE_ODD, 1'b0, 1'b0, 1'b0);
      checkOutput("two_beat_no_early_valid", 32'(out_valid), 32'd0);
      applyStimulus(1'b1, 8'h03, 1'b1, MODE_EVEN, 1'b1, 1'b1, 1'b0);
      checkResult("two_beat", 1'b0, 1'b0, 2, 1'b0);
      consume("two_beat");

      // Beats separated by in_valid gaps: 8'h01, gap, 8'h02, gap, 8'h04 even -> 3 ones -> 1.
      applyStimulus(1'b1, 8'h01, 1'b0, MODE_EVEN, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, 8'hFF, 1'b1, MODE_EVEN, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 8'h02, 1'b0, MODE_EVEN, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, 8'hFF, 1'b1, MODE_EVEN, 1'b0, 1'b0, 1'b0);
      checkOutput("gap_no_valid", 32'(out_valid), 32'd0);
      applyStimulus(1'b1, 8'h04, 1'b1, MODE_EVEN, 1'b0, 1'b0, 1'b0);
      checkResult("gap", 1'b1, 1'b0, 3, 1'b0);
      consume("gap");

      // Back-pressure: result held for 5 clocks while a new beat is offered.
      applyStimulus(1'b1, 8'h01, 1'b1, MODE_EVEN, 1'b0, 1'b0, 1'b0);
      held_par   = out_parity;
      held_beats = out_beats;
      checkOutput("hold_first_parity", 32'(held_par), 32'd1);
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b1, 8'h00, 1'b1, MODE_EVEN, 1'b0, 1'b0, 1'b0);
         checkOutput($sformatf("hold%0d_in_ready", i), 32'(in_ready), 32'd0);
         checkOutput($sformatf("hold%0d_valid", i), 32'(out_valid), 32'd1);
         checkOutput($sformatf("hold%0d_parity", i), 32'(out_parity), 32'(held_par));
         checkOutput($sformatf("hold%0d_beats", i), 32'(out_beats), 32'(held_beats));
      end
      consume("hold");
      checkOutput("hold_parity_kept", 32'(out_parity), 32'd1);

      // Exactly MAX_BEATS beats: saturated count but no overflow.
      for (int i = 0; i < MAX_BEATS; i++)
         applyStimulus(1'b1, 8'hFF, (i == MAX_BEATS - 1), MODE_EVEN, 1'b0, 1'b0, 1'b0);
      checkResult("beats16", 1'b0, 1'b0, 16, 1'b0);
      consume("beats16");

      // 18 beats of 8'hFF: 144 ones, even parity 0, count saturates, overflow set.
      for (int i = 0; i < 18; i++)
         applyStimulus(1'b1, 8'hFF, (i == 17), MODE_EVEN, 1'b0, 1'b0, 1'b0);
      checkResult("beats18", 1'b0, 1'b0, 16, 1'b1);
      consume("beats18");

      // 17 beats of 8'h01: 17 ones, even parity 1.
      for (int i = 0; i < 17; i++)
         applyStimulus(1'b1, 8'h01, (i == 16), MODE_EVEN, 1'b0, 1'b0, 1'b0);
      checkResult("beats17", 1'b1, 1'b0, 16, 1'b1);
      consume("beats17");

      // Reset after 2 of 4 beats discards the packet.
      applyStimulus(1'b1, 8'h01, 1'b0, MODE_EVEN, 1'b0, 1'b0, 1'b1);
      applyStimulus(1'b1, 8'h01, 1'b0, MODE_EVEN, 1'b0, 1'b0, 1'b1);
      rst = 1'b1;
      #1;
      checkOutput("midrst_in_ready", 32'(in_ready), 32'd0);
      applyStimulus(1'b0, '0, 1'b0, MODE_EVEN, 1'b0, 1'b0, 1'b1);
      rst = 1'b0;
      applyStimulus(1'b0, '0, 1'b0, MODE_EVEN, 1'b0, 1'b0, 1'b1);
      applyStimulus(1'b0, '0, 1'b0, MODE_EVEN, 1'b0, 1'b0, 1'b1);
      checkOutput("midrst_no_valid", 32'(out_valid), 32'd0);
      applyStimulus(1'b1, 8'h01, 1'b1, MODE_EVEN, 1'b0, 1'b0, 1'b0);
      checkResult("after_rst", 1'b1, 1'b0, 1, 1'b0);

      // Reset while a result is pending drops it.
      rst = 1'b1;
      applyStimulus(1'b0, '0, 1'b0, MODE_EVEN, 1'b0, 1'b0, 1'b0);
      rst = 1'b0;
      #1;
      checkOutput("holdrst_valid", 32'(out_valid), 32'd0);
      checkOutput("holdrst_parity", 32'(out_parity), 32'd0);
      checkOutput("holdrst_in_ready", 32'(in_ready), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
